rifl_tx_encode_pipe: RTL
========================

# rifl_tx_encode_pipe

Registered, back-pressure-tolerant successor to the RIFL TX lane encoder. Converts an AXI4-Stream lane beat into a PAYLOAD_WIDTH+2 bit RIFL frame payload (2-bit meta plus data, with the byte count folded into the low byte of partial beats). A two-entry skid buffer gives both output and `tx_lane_tready` registered timing. It sits between the per-lane TX AXIS adapter and the RIFL TX framer, and adds packet statistics and optional tkeep legality checking.

## Interface
- `PAYLOAD_WIDTH`, 240: lane data width in bits. Must be a multiple of 8, with 16 ≤ W ≤ 2048.
- `STAT_W`, 32: width of the packet counter.
- `clk` in 1: lane clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `tx_lane_tdata` in PAYLOAD_WIDTH: beat data, valid bytes MSB-aligned.
- `tx_lane_tkeep` in PAYLOAD_WIDTH/8: byte enables. Bit 0 set means a full beat.
- `tx_lane_tlast` in 1: end of packet.
- `tx_lane_tvalid` in 1: beat valid.
- `tx_lane_tready` out 1: registered ready.
- `rifl_tx_payload` out PAYLOAD_WIDTH+2: registered `{meta[1:0], data}`.
- `rifl_tx_ready` in 1: the framer consumes `rifl_tx_payload` on this cycle.
- `stat_pkt_cnt` out STAT_W: number of accepted tlast beats. Wraps at 2^STAT_W.
- `stat_keep_err` out 1: sticky tkeep violation flag (see Configuration).

## Operation
- Meta encoding: `meta[0]` = ABV (all bytes valid), `meta[1]` = EOP.
  - 00: idle (payload all zero).
  - 01: full, not last.
  - 10: last, partial.
  - 11: last, full.
- Encode rule for an accepted beat:
  - If `tkeep[0]=1`: `{tlast,1'b1,tdata}`.
  - Else: `{tlast,1'b0,tdata[W-1:8],cnt}`, where `cnt` = popcount(tkeep), zero-extended to 8 bits.
  - A partial beat without tlast therefore encodes meta 00 and is lost. This is illegal and is flagged when the check is enabled.
- The byte count is computed with a `$clog2(PAYLOAD_WIDTH/8+1)`-bit adder tree. It must close in one cycle at W=2048.
- Storage is an output register (OUT) plus a skid register (SKID), each holding an encoded payload and a valid bit.
- A beat is accepted when `tx_lane_tvalid & tx_lane_tready`.
- Per-cycle update, in priority order:
  - If `rifl_tx_ready`, or OUT is empty: OUT loads SKID if SKID is valid. Otherwise OUT loads the accepted beat. Otherwise OUT loads idle (all zero, invalid).
  - If OUT stalls (`~rifl_tx_ready` and OUT valid) and a beat is accepted: the beat goes to SKID.
  - An accepted beat is never dropped or reordered.
- `tx_lane_tready` next = ~SKID valid next.
- `stat_pkt_cnt` increments on each accepted beat with tlast, regardless of error status.
- While `rifl_tx_ready=0`, `rifl_tx_payload` is held bit-stable.

## Timing
- Reset (`rst_n=0` at a `clk` edge):
  - `rifl_tx_payload`=0.
  - OUT and SKID invalid.
  - `tx_lane_tready`=0.
  - `stat_pkt_cnt`=0.
  - `stat_keep_err`=0.
- `tx_lane_tready` rises to 1 on the first edge with `rst_n=1`.
- Reset mid-packet discards OUT and SKID contents. No partial-packet recovery is attempted.
- Latency is one cycle: a beat accepted at edge N appears on `rifl_tx_payload` after edge N.
- Throughput is one beat per cycle while `rifl_tx_ready=1`.
- When `rifl_tx_ready` falls with OUT valid, at most one more beat is accepted (into SKID). `tx_lane_tready` deasserts the following cycle.
- When `rifl_tx_ready` rises with SKID valid:
  - SKID moves to OUT.
  - `tx_lane_tready` returns to 1 one cycle later.
  - No input beat is accepted in the same cycle SKID drains.
- Idle output: with no data and `rifl_tx_ready=1`, OUT becomes zero on the next edge.

## Configuration
- `RIFL_ENCODE_KEEP_CHECK_EN` defined: each accepted beat is checked for three violations:
  - tkeep is not of the form 1…10…0 (contiguous from the MSB);
  - tkeep == 0;
  - `tkeep[0]=0` with `tlast=0`.
- On any violation: `stat_keep_err` is set on the next edge and stays set until reset. The beat is still encoded and forwarded unchanged.
- Undefined: no check logic is generated and `stat_keep_err` is tied to 0.

## Structure
- Package `rifl_pkg` holds:
  - meta localparams `RIFL_META_IDLE/FULL/EOP_PART/EOP_FULL`;
  - the `rifl_byte_cnt` popcount function;
  - the `RIFL_CNT_BYTE_W=8` constant.
- Sub-module `rifl_skid_buf`: a generic two-entry registered skid buffer with payload-width parameter, instantiated once. The encode logic sits combinationally in front of it.

## Test plan
- Reset, then 3 full beats (W=240, tkeep=30'h3FFFFFFF), last beat with tlast, `rifl_tx_ready=1` → meta 01,01,11, data unchanged, each one cycle after accept; `stat_pkt_cnt`=1.
- Partial last beat: tkeep=30'h3FFFFC00 (20 bytes), tlast=1 → meta 10, low byte 8'h14, bits [239:8] unchanged.
- Back-pressure: continuous tvalid, `rifl_tx_ready` low for 5 cycles → exactly 1 beat lands in SKID, tready low from the second stall cycle; all beats are delivered in order with no duplicates after release.
- Random tvalid/`rifl_tx_ready` over 10k beats against a scoreboard → sequence matches, and the payload is stable while ready is low.
- With `RIFL_ENCODE_KEEP_CHECK_EN`: tkeep=30'h3FFF00FF, tlast=1 → `stat_keep_err`=1 next cycle, beat still forwarded; without the macro, `stat_keep_err` stays 0.
- `rst_n` asserted while SKID is full → all outputs zero next edge, tready=1 one edge after release.

Source files
------------

// File: rtl/rifl_pkg.sv
// RIFL lane encode shared definitions: meta codes, byte-count width, popcount.
// Latency: n/a (constants and a combinational helper only).
// Backpressure: n/a.
package rifl_pkg;

  // meta[1] = EOP, meta[0] = ABV (all bytes valid)
  localparam logic [1:0] RIFL_META_IDLE     = 2'b00;
  localparam logic [1:0] RIFL_META_FULL     = 2'b01;
  localparam logic [1:0] RIFL_META_EOP_PART = 2'b10;
  localparam logic [1:0] RIFL_META_EOP_FULL = 2'b11;

  // Byte count folded into the low byte of a partial beat.
  localparam int RIFL_CNT_BYTE_W = 8;

  // Widest supported lane (2048 bits) has 256 byte enables.
  localparam int RIFL_KEEP_MAX_W = 256;

  // Popcount of the byte enables as a balanced pairwise adder tree (log2 depth),
  // so the count closes in one cycle even on the widest lane. Only a completely
  // full 256-byte keep would overflow 8 bits, and full beats never use the count.
  // Unused upper keep bits are zero-padded by the caller and trimmed by synthesis.
  function automatic logic [RIFL_CNT_BYTE_W-1:0] rifl_byte_cnt(
    input logic [RIFL_KEEP_MAX_W-1:0] keep
  );
    logic [RIFL_CNT_BYTE_W-1:0] node [RIFL_KEEP_MAX_W];
    for (int i = 0; i < RIFL_KEEP_MAX_W; i++) begin
      node[i] = RIFL_CNT_BYTE_W'(keep[i]);
    end
    for (int span = 1; span < RIFL_KEEP_MAX_W; span = span * 2) begin
      for (int i = 0; i < RIFL_KEEP_MAX_W; i = i + 2 * span) begin
        node[i] = node[i] + node[i + span];
      end
    end
    return node[0];
  endfunction

endpackage

// File: rtl/rifl_skid_buf.sv
// Generic two-entry registered skid buffer (OUT register plus SKID register).
// Latency: 1 cycle from accepted input to out_dat.
// Backpressure: in_rdy is registered; one extra beat lands in SKID when out stalls.
//
// Ports: clk, rst_n (sync, active-low); in_dat/in_vld/in_rdy upstream side;
//        out_dat/out_vld/out_rdy downstream side (out_rdy = consumed this cycle).
module rifl_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_dat,
  input  logic         in_vld,
  output logic         in_rdy,
  output logic [W-1:0] out_dat,
  output logic         out_vld,
  input  logic         out_rdy
);

  logic [W-1:0] skid_dat;
  logic         skid_vld;
  logic         in_acc;
  logic         out_load;
  logic         skid_vld_nxt;

  always_comb begin
    in_acc   = in_vld & in_rdy;
    out_load = out_rdy | ~out_vld;
    skid_vld_nxt = skid_vld;
    if (out_load) begin
      // OUT takes SKID if it was full, so SKID always empties on a load.
      skid_vld_nxt = 1'b0;
    end else if (in_acc) begin
      skid_vld_nxt = 1'b1;
    end
  end

  // OUT data is left stale when it goes invalid; the consumer masks with out_vld.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_dat  <= '0;
      out_vld  <= 1'b0;
      skid_dat <= '0;
      skid_vld <= 1'b0;
      in_rdy   <= 1'b0;
    end else begin
      if (out_load) begin
        if (skid_vld) begin
          out_dat <= skid_dat;
          out_vld <= 1'b1;
        end else if (in_acc) begin
          out_dat <= in_dat;
          out_vld <= 1'b1;
        end else begin
          out_vld <= 1'b0;
        end
      end else if (in_acc) begin
        skid_dat <= in_dat;
      end
      skid_vld <= skid_vld_nxt;
      // in_rdy is low whenever SKID is full, so SKID never overflows.
      in_rdy   <= ~skid_vld_nxt;
    end
  end

endmodule

// File: rtl/rifl_tx_encode_pipe.sv
// RIFL TX lane encoder: AXIS beat -> {meta[1:0], data} with byte count on partial beats.
// Latency: 1 cycle from accept to rifl_tx_payload.
// Backpressure: registered tx_lane_tready via 2-entry skid; payload held while rifl_tx_ready=0.
//
// Ports: clk, rst_n (sync, active-low); tx_lane_tdata/tkeep/tlast/tvalid/tready lane input;
//        rifl_tx_payload / rifl_tx_ready framer side; stat_pkt_cnt, stat_keep_err statistics.
// Optional: define RIFL_ENCODE_KEEP_CHECK_EN to build the tkeep legality checker;
//        otherwise stat_keep_err is tied to 0.
module rifl_tx_encode_pipe
  import rifl_pkg::*;
#(
  parameter int PAYLOAD_WIDTH = 240,
  parameter int STAT_W        = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [PAYLOAD_WIDTH-1:0]   tx_lane_tdata,
  input  logic [PAYLOAD_WIDTH/8-1:0] tx_lane_tkeep,
  input  logic                       tx_lane_tlast,
  input  logic                       tx_lane_tvalid,
  output logic                       tx_lane_tready,
  output logic [PAYLOAD_WIDTH+1:0]   rifl_tx_payload,
  input  logic                       rifl_tx_ready,
  output logic [STAT_W-1:0]          stat_pkt_cnt,
  output logic                       stat_keep_err
);

  localparam int KEEP_W = PAYLOAD_WIDTH / 8;
  localparam int PAY_W  = PAYLOAD_WIDTH + 2;

  logic [RIFL_CNT_BYTE_W-1:0] byte_cnt;
  logic [PAY_W-1:0]           enc_dat;
  logic [PAY_W-1:0]           out_dat;
  logic                       out_vld;
  logic                       beat_acc;

  always_comb begin
    byte_cnt = rifl_byte_cnt(RIFL_KEEP_MAX_W'(tx_lane_tkeep));
    if (tx_lane_tkeep[0]) begin
      enc_dat = {(tx_lane_tlast ? RIFL_META_EOP_FULL : RIFL_META_FULL), tx_lane_tdata};
    end else begin
      // A partial non-last beat encodes as idle meta and is lost downstream.
      enc_dat = {(tx_lane_tlast ? RIFL_META_EOP_PART : RIFL_META_IDLE),
                 tx_lane_tdata[PAYLOAD_WIDTH-1:8], byte_cnt};
    end
    beat_acc = tx_lane_tvalid & tx_lane_tready;
  end

  rifl_skid_buf #(
    .W (PAY_W)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_dat  (enc_dat),
    .in_vld  (tx_lane_tvalid),
    .in_rdy  (tx_lane_tready),
    .out_dat (out_dat),
    .out_vld (out_vld),
    .out_rdy (rifl_tx_ready)
  );

  // Idle output is all zero; the buffer leaves stale data in an invalid OUT.
  assign rifl_tx_payload = out_dat & {PAY_W{out_vld}};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_pkt_cnt <= '0;
    end else if (beat_acc & tx_lane_tlast) begin
      stat_pkt_cnt <= stat_pkt_cnt + STAT_W'(1);
    end
  end

`ifdef RIFL_ENCODE_KEEP_CHECK_EN
  logic [KEEP_W-1:0] keep_inv;
  logic              keep_viol;
  logic              keep_err_q;

  // Legal keep is 1..10..0: its inverse is 0..01..1, i.e. inv & (inv+1) == 0.
  // An all-zero keep passes that test, so it is flagged separately.
  always_comb begin
    keep_inv  = ~tx_lane_tkeep;
    keep_viol = ((keep_inv & (keep_inv + KEEP_W'(1))) != '0) |
                (tx_lane_tkeep == '0) |
                (~tx_lane_tkeep[0] & ~tx_lane_tlast);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      keep_err_q <= 1'b0;
    end else if (beat_acc & keep_viol) begin
      keep_err_q <= 1'b1;
    end
  end

  assign stat_keep_err = keep_err_q;
`else
  assign stat_keep_err = 1'b0;
`endif

endmodule
